// File: rtl/spi_slave_if.sv
// Byte-oriented SPI responder bus: serial pins toward the master plus the
// parallel TX/RX side toward the local peripheral logic.
interface spi_slave_if;
  logic       sclk_i;
  logic       mosi_i;
  logic       ss_n_i;
  logic       miso_o;
  logic [7:0] din_i;
  logic       load_i;
  logic       tx_ready_o;
  logic [7:0] dout_o;
  logic       rx_done_tick_o;
  logic       tx_underrun_o;
  logic       busy_o;

  modport slave (
    input  sclk_i, mosi_i, ss_n_i, din_i, load_i,
    output miso_o, tx_ready_o, dout_o, rx_done_tick_o, tx_underrun_o, busy_o
  );

  modport master (
    output sclk_i, mosi_i, ss_n_i, din_i, load_i,
    input  miso_o, tx_ready_o, dout_o, rx_done_tick_o, tx_underrun_o, busy_o
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples SCLK/MOSI/SS_N in clk_i, exchanges one byte
// per 8 SCLK cycles with a single-entry TX buffer and a parallel RX register.
module spi_slave #(
  parameter bit         CPOL      = 1'b0,
  parameter bit         CPHA      = 1'b0,
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input logic        clk_i,
  input logic        rst_i,
  spi_slave_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e     state_q, state_d;
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [1:0] ss_sync_q, ss_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] txbuf_q, txbuf_d;
  logic       txbuf_full_q, txbuf_full_d;
  logic       rx_done_q, rx_done_d;
  logic       underrun_q, underrun_d;

  logic sclk_now, sclk_prev, ss_s, mosi_s;
  logic lead, trail, capture, launch, reload;

  // sclk_sync_q[2] is the history flop used only for edge detection
  assign sclk_now  = sclk_sync_q[1];
  assign sclk_prev = sclk_sync_q[2];
  assign ss_s      = ss_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign lead      = (sclk_prev == CPOL) && (sclk_now != CPOL);
  assign trail     = (sclk_prev != CPOL) && (sclk_now == CPOL);
  assign capture   = CPHA ? trail : lead;
  assign launch    = CPHA ? lead  : trail;

  always_comb begin
    sclk_sync_d  = {sclk_sync_q[1:0], bus.sclk_i};
    ss_sync_d    = {ss_sync_q[0], bus.ss_n_i};
    mosi_sync_d  = {mosi_sync_q[0], bus.mosi_i};
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    dout_d       = dout_q;
    txbuf_d      = txbuf_q;
    txbuf_full_d = txbuf_full_q;
    rx_done_d    = 1'b0;
    underrun_d   = 1'b0;
    reload       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!ss_s) begin
          state_d   = SHIFT;
          bit_cnt_d = 3'd0;
          reload    = !CPHA;
        end
      end
      SHIFT: begin
        if (ss_s) begin
          // Frame released: partial bytes in both directions are abandoned
          state_d    = IDLE;
          bit_cnt_d  = 3'd0;
          tx_shift_d = 8'h00;
        end else begin
          if (capture) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              dout_d    = {rx_shift_q[6:0], mosi_s};
              rx_done_d = 1'b1;
            end
          end
          // bit_cnt==0 on a launch edge marks the start of a new byte
          if (launch) begin
            if (bit_cnt_q == 3'd0) reload = 1'b1;
            else                   tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (reload) begin
      if (txbuf_full_q) begin
        tx_shift_d   = txbuf_q;
        txbuf_full_d = 1'b0;
      end else begin
        tx_shift_d = FILL_BYTE;
        underrun_d = 1'b1;
      end
    end

    // Loads only land in an empty buffer, so a same-cycle reload never collides
    if (bus.load_i && !txbuf_full_q) begin
      txbuf_d      = bus.din_i;
      txbuf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      sclk_sync_q  <= {3{CPOL}};
      ss_sync_q    <= 2'b11;
      mosi_sync_q  <= 2'b00;
      bit_cnt_q    <= 3'd0;
      rx_shift_q   <= 8'h00;
      tx_shift_q   <= 8'h00;
      dout_q       <= 8'h00;
      txbuf_q      <= 8'h00;
      txbuf_full_q <= 1'b0;
      rx_done_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclk_sync_q  <= sclk_sync_d;
      ss_sync_q    <= ss_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      dout_q       <= dout_d;
      txbuf_q      <= txbuf_d;
      txbuf_full_q <= txbuf_full_d;
      rx_done_q    <= rx_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign bus.miso_o         = tx_shift_q[7];
  assign bus.tx_ready_o     = !txbuf_full_q;
  assign bus.dout_o         = dout_q;
  assign bus.rx_done_tick_o = rx_done_q;
  assign bus.tx_underrun_o  = underrun_q;
  assign bus.busy_o         = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: three instances (CPOL/CPHA 0/0, 1/1, 0/1) driven by a
// behavioural SPI master; directed vector table, corner sequences, random frames.
module tb_spi_slave;
  localparam int H = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       mosi = 1'b0;
  logic [7:0] din  = 8'h00;
  logic [2:0] sclk = 3'b010;
  logic [2:0] ss_n = 3'b111;
  logic [2:0] load = 3'b000;
  logic [2:0] miso_a, txr_a, rxd_a, und_a, busy_a;
  logic [2:0][7:0] dout_a;

  for (genvar g = 0; g < 3; g++) begin : gen_m
    localparam bit GCPOL = (g == 1);
    localparam bit GCPHA = (g != 0);
    spi_slave_if bus ();
    assign bus.sclk_i = sclk[g];
    assign bus.mosi_i = mosi;
    assign bus.ss_n_i = ss_n[g];
    assign bus.din_i  = din;
    assign bus.load_i = load[g];
    assign miso_a[g]  = bus.miso_o;
    assign txr_a[g]   = bus.tx_ready_o;
    assign dout_a[g]  = bus.dout_o;
    assign rxd_a[g]   = bus.rx_done_tick_o;
    assign und_a[g]   = bus.tx_underrun_o;
    assign busy_a[g]  = bus.busy_o;
    spi_slave #(.CPOL(GCPOL), .CPHA(GCPHA), .FILL_BYTE(8'h00)) u_dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus.slave)
    );
  end

  // Event log: every rx_done pulse records dout, every underrun pulse is counted
  logic [7:0] rxq[$];
  int         und_cnt = 0;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rxd_a[k]) rxq.push_back(dout_a[k]);
      if (und_a[k]) und_cnt++;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic cpol_of(input int m);
    return (m == 1);
  endfunction

  function automatic logic cpha_of(input int m);
    return (m != 0);
  endfunction

  task automatic load_byte(input int m, input logic [7:0] b);
    @(negedge clk);
    din     = b;
    load[m] = 1'b1;
    @(negedge clk);
    load[m] = 1'b0;
  endtask

  // One SCLK period as master; samples miso on the master's capture edge
  task automatic bit_x(input int m, input logic v, input bit last, output logic s);
    if (!cpha_of(m)) begin
      mosi = v;
      repeat (H) @(negedge clk);
      sclk[m] = ~cpol_of(m);
      s = miso_a[m];
      repeat (H) @(negedge clk);
      sclk[m] = cpol_of(m);
      if (last) ss_n[m] = 1'b1;
    end else begin
      sclk[m] = ~cpol_of(m);
      mosi = v;
      repeat (H) @(negedge clk);
      sclk[m] = cpol_of(m);
      s = miso_a[m];
      repeat (H) @(negedge clk);
      if (last) ss_n[m] = 1'b1;
    end
  endtask

  // Bit streams are left-aligned: bit b of the frame lives at [23-b]
  task automatic frame(input int m, input logic [23:0] mtx, input int nbits, output logic [23:0] got);
    logic s;
    got = '0;
    ss_n[m] = 1'b0;
    repeat (H) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      bit_x(m, mtx[23-b], (b == nbits - 1), s);
      got[23-b] = s;
    end
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    int         mode;
    bit         do_load;
    logic [7:0] ld;
    logic [7:0] mb;
    logic [7:0] exp_miso;
    logic [7:0] exp_dout;
    int         exp_und;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[4];
    logic [23:0] got, exp, mask, mtx;
    logic        s;
    int          b0, u0, m, nl, nbits, nf, und_exp;
    logic [7:0]  rb, e;
    bit          mfull[3];
    logic [7:0]  mval[3];
    logic [7:0]  mdout[3];

    tbl[0] = '{0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
    tbl[1] = '{1, 1'b1, 8'hC3, 8'h96, 8'hC3, 8'h96, 0};
    tbl[2] = '{2, 1'b1, 8'hC3, 8'h96, 8'hC3, 8'h96, 0};
    tbl[3] = '{0, 1'b0, 8'h00, 8'h5A, 8'h00, 8'h5A, 1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_miso", miso_a[k], 1'b0);
      check("rst_tx_ready", txr_a[k], 1'b1);
      check("rst_dout", dout_a[k], 8'h00);
      check("rst_rx_done", rxd_a[k], 1'b0);
      check("rst_underrun", und_a[k], 1'b0);
      check("rst_busy", busy_a[k], 1'b0);
    end

    for (int i = 0; i < 4; i++) begin
      m = tbl[i].mode;
      if (tbl[i].do_load) load_byte(m, tbl[i].ld);
      b0 = rxq.size();
      u0 = und_cnt;
      frame(m, {tbl[i].mb, 16'h0}, 8, got);
      check("vec_miso", got[23:16], tbl[i].exp_miso);
      check("vec_dout", dout_a[m], tbl[i].exp_dout);
      check("vec_rx_ticks", rxq.size() - b0, 1);
      check("vec_underruns", und_cnt - u0, tbl[i].exp_und);
      check("vec_tx_ready", txr_a[m], 1'b1);
      check("vec_busy", busy_a[m], 1'b0);
    end

    // Back-to-back bytes in one frame, only the first one buffered
    load_byte(0, 8'h5A);
    b0 = rxq.size();
    u0 = und_cnt;
    frame(0, 24'h01FE00, 16, got);
    check("b2b_miso0", got[23:16], 8'h5A);
    check("b2b_miso1", got[15:8], 8'h00);
    check("b2b_underruns", und_cnt - u0, 1);
    check("b2b_rx_ticks", rxq.size() - b0, 2);
    check("b2b_rx0", rxq[b0], 8'h01);
    check("b2b_rx1", rxq[b0+1], 8'hFE);

    // Frame aborted after 5 bits, then a clean frame
    b0 = rxq.size();
    frame(0, 24'hF00000, 5, got);
    check("abort_rx_ticks", rxq.size() - b0, 0);
    check("abort_dout", dout_a[0], 8'hFE);
    check("abort_busy", busy_a[0], 1'b0);
    b0 = rxq.size();
    frame(0, 24'h690000, 8, got);
    check("after_abort_dout", dout_a[0], 8'h69);
    check("after_abort_ticks", rxq.size() - b0, 1);

    // Second load while the buffer is full is dropped
    load_byte(0, 8'h11);
    load_byte(0, 8'h22);
    check("dbl_tx_ready", txr_a[0], 1'b0);
    frame(0, 24'h810000, 8, got);
    check("dbl_miso", got[23:16], 8'h11);
    check("dbl_tx_ready_after", txr_a[0], 1'b1);
    frame(0, 24'h420000, 8, got);
    check("dbl_miso_next", got[23:16], 8'h00);

    // Reset in the middle of a frame, with a byte waiting in the buffer
    load_byte(0, 8'h33);
    ss_n[0] = 1'b0;
    repeat (H) @(negedge clk);
    for (int b = 0; b < 4; b++) bit_x(0, 1'b1, 1'b0, s);
    load_byte(0, 8'h44);
    check("midrst_tx_ready_pre", txr_a[0], 1'b0);
    check("midrst_busy_pre", busy_a[0], 1'b1);
    @(negedge clk);
    rst = 1'b1;
    ss_n[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_miso", miso_a[0], 1'b0);
    check("midrst_tx_ready", txr_a[0], 1'b1);
    check("midrst_dout", dout_a[0], 8'h00);
    check("midrst_busy", busy_a[0], 1'b0);
    check("midrst_rx_done", rxd_a[0], 1'b0);
    check("midrst_underrun", und_a[0], 1'b0);
    repeat (8) @(negedge clk);
    load_byte(0, 8'h77);
    frame(0, 24'hC50000, 8, got);
    check("postrst_miso", got[23:16], 8'h77);
    check("postrst_dout", dout_a[0], 8'hC5);

    // Randomized frames against a buffer/byte-level model
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mfull[k] = 1'b0;
      mval[k]  = 8'h00;
      mdout[k] = 8'h00;
    end
    repeat (4) @(negedge clk);

    for (int it = 0; it < 40; it++) begin
      m  = $urandom_range(0, 2);
      nl = $urandom_range(0, 2);
      for (int j = 0; j < nl; j++) begin
        rb = 8'($urandom);
        load_byte(m, rb);
        if (!mfull[m]) begin
          mfull[m] = 1'b1;
          mval[m]  = rb;
        end
      end
      check("rnd_tx_ready_pre", txr_a[m], !mfull[m]);
      nbits = $urandom_range(1, 24);
      mtx   = 24'($urandom);
      exp = '0;
      und_exp = 0;
      for (int k = 0; k * 8 < nbits; k++) begin
        if (mfull[m]) begin
          e = mval[m];
          mfull[m] = 1'b0;
        end else begin
          e = 8'h00;
          und_exp++;
        end
        exp[23-8*k -: 8] = e;
      end
      mask = 24'hFFFFFF << (24 - nbits);
      nf = nbits / 8;
      if (nf > 0) mdout[m] = mtx[23-8*(nf-1) -: 8];
      b0 = rxq.size();
      u0 = und_cnt;
      frame(m, mtx, nbits, got);
      check("rnd_miso", got, exp & mask);
      check("rnd_rx_ticks", rxq.size() - b0, nf);
      check("rnd_underruns", und_cnt - u0, und_exp);
      check("rnd_dout", dout_a[m], mdout[m]);
      check("rnd_tx_ready", txr_a[m], !mfull[m]);
      check("rnd_busy", busy_a[m], 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder for the far end of the team's SPI master link (sclk/mosi/miso byte transfers).
- Oversamples SCLK, MOSI and SS_N in the clk_i domain through synchronizers.
- Shifts one byte in on MOSI while shifting one buffered byte out on MISO.
- Used as the on-chip peripheral-side endpoint and as the loop-back partner in the SPI UVM environment.

Parameters:
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = capture on leading edge, launch on trailing edge; 1 = launch on leading edge, capture on trailing edge.
- FILL_BYTE, 8'h00, byte sent when the TX buffer is empty at byte start.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- sclk_i  in  1  SPI clock from master (asynchronous to clk_i).
- mosi_i  in  1  serial data from master.
- ss_n_i  in  1  active-low frame select.
- miso_o  out  1  serial data to master.
- din_i  in  8  byte to transmit.
- load_i  in  1  write din_i into TX buffer.
- tx_ready_o  out  1  TX buffer empty; load_i accepted.
- dout_o  out  8  last received byte.
- rx_done_tick_o  out  1  one-cycle pulse; dout_o updated.
- tx_underrun_o  out  1  one-cycle pulse; FILL_BYTE was used.
- busy_o  out  1  frame active (state SHIFT).

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset values:
  - miso_o=0, tx_ready_o=1, dout_o=0, rx_done_tick_o=0, tx_underrun_o=0, busy_o=0.
  - Internal: bit_cnt=0, rx_shift=0, tx_shift=0, TX buffer empty.
  - Synchronizer stages: sclk stages=CPOL, ss_n stages=1, mosi stages=0.
- Synchronizers and edge detection:
  - 2-flop synchronizers on sclk_i, mosi_i and ss_n_i; one extra sclk register for edge detection.
  - Leading edge = idle-to-active transition of the synced SCLK; trailing edge = active-to-idle.
  - Input-to-action latency is 3 clk_i cycles.
  - Requirement: SCLK high and low times >= 4 clk_i cycles, and ss_n_i setup to the first SCLK edge >= 4 clk_i cycles.
- States: IDLE, SHIFT.
- IDLE -> SHIFT when synced ss_n falls:
  - bit_cnt=0; busy_o=1.
  - CPHA=0: load tx_shift from the TX buffer (or FILL_BYTE plus tx_underrun_o pulse) and drive miso_o=bit7 in the same cycle.
- SHIFT, capture edge:
  - rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt++.
  - On the 8th capture: dout_o <= {rx_shift[6:0], mosi_sync}, rx_done_tick_o=1 for one cycle, bit_cnt wraps to 0, state stays SHIFT (back-to-back bytes allowed).
- SHIFT, launch edge:
  - CPHA=0: trailing edge. After captures 1-7, shift tx_shift left and drive the next bit. After the 8th capture, the trailing edge reloads tx_shift from buffer/FILL_BYTE and drives its bit7.
  - CPHA=1: leading edge. When bit_cnt==0, reload tx_shift and drive bit7; otherwise shift and drive the next bit.
- TX buffer:
  - load_i with tx_ready_o=1 stores din_i and sets tx_ready_o=0 next cycle.
  - load_i with tx_ready_o=0 is ignored; the buffer is not overwritten.
  - Consumption (reload) empties the buffer: tx_ready_o=1 next cycle.
  - MSB is transmitted first.
- Simultaneous load_i and consumption with the buffer empty: the reload uses FILL_BYTE and pulses tx_underrun_o; din_i is stored for the next byte.
- Synced ss_n rises in SHIFT (any bit_cnt):
  - Go to IDLE; bit_cnt=0; busy_o=0; miso_o=0.
  - Partial rx byte discarded, no rx_done_tick_o; dout_o holds.
  - TX buffer contents retained; a partially sent tx_shift byte is dropped.
- SCLK edges while in IDLE are ignored.
- rst_i asserted mid-frame: all state returns to reset values on the next clk_i edge; the buffered TX byte is lost.

Test Plan:
- Mode 0, load 8'hA5, frame with master sending 8'h3C -> miso bits 1,0,1,0,0,1,0,1; dout_o=8'h3C; one rx_done_tick_o; tx_ready_o=1 after first reload.
- Two back-to-back bytes without releasing ss_n; master sends 8'h01, 8'hFE; only first byte loaded (8'h5A) -> second byte sends 8'h00 with one tx_underrun_o pulse; two rx_done_tick_o pulses with dout_o=8'h01 then 8'hFE.
- ss_n_i raised after 5 SCLK cycles -> no rx_done_tick_o, dout_o unchanged, busy_o=0, next full frame receives correctly from bit_cnt=0.
- load_i of 8'h11 then 8'h22 while tx_ready_o=0 -> 8'h11 transmitted, 8'h22 never appears on miso.
- Run CPOL/CPHA = 1/1 and 0/1 with din=8'hC3, master sends 8'h96 -> miso=8'hC3 on the correct edges, dout_o=8'h96.
- rst_i pulsed at bit 4 of a frame -> all outputs at reset values next cycle; after re-load of 8'h77 and a new frame, exchange completes normally.
